demo_rx_fifo: RTL and testbench
===============================

Name: demo_rx_fifo

Overview:
- Receive-side buffering stage sitting directly downstream of the demo bus driven by the testbench driver clocking block (valid/ready/data on clk).
- Accepts words from the driver side, stores them in a first-word-fall-through FIFO and presents them to the consuming logic with its own valid/ready handshake.
- Provides occupancy, almost-full, flush and transfer counters so that the monitor side can check flow control and data ordering.

Parameters:
- DATA_W, 32, width of each data word; the default comes from the shared package constant.
- DEPTH, 8, number of FIFO entries; must be a power of 2, minimum 2.
- AF_LEVEL, 6, occupancy at or above which almost_full asserts; legal range 1..DEPTH.
- CNT_W, 16, width of the transfer counters.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream word valid.
- in_data  in  DATA_W  upstream word.
- in_ready  out  1  FIFO can accept a word.
- out_valid  out  1  head word available.
- out_data  out  DATA_W  head word (FWFT).
- out_ready  in  1  downstream accepts the head word.
- flush  in  1  synchronous clear of contents.
- count  out  $clog2(DEPTH)+1  current occupancy.
- almost_full  out  1  count >= AF_LEVEL.
- in_cnt  out  CNT_W  accepted pushes, wrapping.
- out_cnt  out  CNT_W  completed pops, wrapping.

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=rd_ptr=0, count=0, in_cnt=out_cnt=0. Outputs during reset: in_ready=1, out_valid=0, almost_full=0. out_data is don't-care while out_valid=0. Memory contents are not reset.
- Push occurs when in_valid && in_ready at a rising edge. Pop occurs when out_valid && out_ready at a rising edge.
- in_ready = (count != DEPTH). It is registered/derived from state only and has no combinational path from out_ready; there is no bypass when full.
- out_valid = (count != 0). out_data = mem[rd_ptr] combinationally (FWFT).
- Latency: a word pushed at edge N is visible on out_valid/out_data after edge N, so it can be popped at edge N+1.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is tracked by the count register, not by pointer comparison.
- When full, in_valid is ignored (backpressure) and data is held by the source. When empty, out_ready is ignored.
- in_valid may deassert without completing a handshake; out_data must remain stable while out_valid=1 and no pop has occurred.
- flush=1 at an edge: pointers and count go to 0 and any simultaneous push or pop in that cycle is discarded. in_cnt/out_cnt are not cleared by flush and do not increment in the flush cycle.
- in_cnt increments by 1 per push and out_cnt by 1 per pop; both wrap from 2^CNT_W-1 to 0.
- almost_full is computed combinationally from count.
- Reset asserted mid-burst: state clears immediately. The first push after reset release is at most 1 edge later and is stored at entry 0.
- Two small controls (push/pop enables, not a multi-state FSM) drive a counter and two pointers. There are no X states: illegal parameters are caught by an elaboration-time assertion on DEPTH being a power of 2 and on the AF_LEVEL range.

Decomposition:
- Shared package demo_dec: DATA_W constant, data_t typedef (logic [DATA_W-1:0]), and a DEPTH default constant.
- Sub-module demo_fifo_mem: a DEPTH x DATA_W register array with a synchronous write port (we, waddr, wdata) and a combinational read port (raddr, rdata).
- demo_rx_fifo holds the pointers, count, handshake logic and counters.

Test Plan (DEPTH=8, AF_LEVEL=6):
- Reset, then push 0x11,0x22,0x33 with out_ready=0: count=3, out_data=0x11, in_cnt=3. Then out_ready=1 for 3 cycles: pops 0x11,0x22,0x33 in order, count=0, out_cnt=3.
- Push 8 words 0xA0..0xA7 with no pop: almost_full rises on the 6th push, in_ready=0 after the 8th. A 9th word 0xFF is held for 3 cycles and not accepted. One pop is issued, after which 0xFF is accepted and later pops last.
- Hold count=4 with in_valid=out_ready=1 for 20 cycles on an incrementing data stream: count stays 4, pointers wrap, and output order equals input order.
- Fill with 5 words, then assert flush together with in_valid=1 and out_ready=1: next cycle count=0, out_valid=0, in_cnt=5, out_cnt=0.
- Assert rst_n=0 asynchronously mid-cycle with count=7: outputs clear immediately without waiting for a clock edge. After release, push 0x5A: out_data=0x5A, count=1.
- Preload in_cnt to near wrap by running 65537 push/pop pairs: in_cnt=out_cnt=1, showing the wrap from 0xFFFF to 0x0000.

Source files
------------

// File: rtl/demo_dec.sv
// Shared constants and types for the demo receive path.
package demo_dec;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 8;

    typedef logic [DATA_W_DEF-1:0] data_t;
endpackage

// File: rtl/demo_fifo_mem.sv
// Register-array storage for the receive FIFO: synchronous write, combinational read.
module demo_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    // One write-enabled register per entry; contents are deliberately never reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (we && (waddr == AW'(gi))) begin
                mem_q[gi] <= wdata;
            end
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/demo_rx_fifo.sv
// First-word-fall-through receive FIFO with occupancy, almost-full, flush and transfer counters.
module demo_rx_fifo
    import demo_dec::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AF_LEVEL = 6,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic [CNT_W-1:0]           in_cnt,
    output logic [CNT_W-1:0]           out_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "demo_rx_fifo: DEPTH must be a power of 2 and at least 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $fatal(1, "demo_rx_fifo: AF_LEVEL must lie in 1..DEPTH");
    end

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             push, pop;

    assign in_ready    = (count_q != CW'(DEPTH));
    assign out_valid   = (count_q != '0);
    assign almost_full = (count_q >= CW'(AF_LEVEL));
    assign count       = count_q;
    assign in_cnt      = in_cnt_q;
    assign out_cnt     = out_cnt_q;

    // A flush cycle swallows any handshake that coincides with it.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                in_cnt_d = in_cnt_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                out_cnt_d = out_cnt_q + CNT_W'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    demo_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .we     (push),
        .waddr  (wr_ptr_q),
        .wdata  (in_data),
        .raddr  (rd_ptr_q),
        .rdata  (out_data)
    );
endmodule

// File: tb/tb_demo_rx_fifo.sv
// Self-checking bench for demo_rx_fifo: queue-based reference model plus directed and random scenarios.
module tb_demo_rx_fifo;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        flush;
    logic [3:0]  count;
    logic        almost_full;
    logic [15:0] in_cnt;
    logic [15:0] out_cnt;

    int tests = 0;
    int fails = 0;

    logic [31:0] q[$];
    logic [31:0] exp_pops[$];
    logic [31:0] got_pops[$];
    int unsigned m_in, m_out;

    demo_rx_fifo #(.DATA_W(32), .DEPTH(DEPTH), .AF_LEVEL(AF), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .flush       (flush),
        .count       (count),
        .almost_full (almost_full),
        .in_cnt      (in_cnt),
        .out_cnt     (out_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock: the model applies the FIFO rules to the queue; DUT pop data is recorded.
    task automatic step();
        bit push, pop;
        push = in_valid && (q.size() != DEPTH) && !flush;
        pop  = out_ready && (q.size() != 0) && !flush;
        if (pop) begin
            exp_pops.push_back(q[0]);
            got_pops.push_back(out_data);
        end
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(in_data);
        end
        if (push) m_in++;
        if (pop) m_out++;
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 0; out_ready = 0; flush = 0; in_data = '0;
        rst_n = 0;
        #3;
        rst_n = 1;
        q.delete(); exp_pops.delete(); got_pops.delete();
        m_in = 0; m_out = 0;
        @(posedge clk); #1;
    endtask

    task automatic push_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1; in_data = base + i;
            step();
        end
        in_valid = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
        tests++; if (almost_full !== 1'b0) begin fails++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
        tests++; if (in_cnt !== 16'd0 || out_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", in_cnt, out_cnt); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic();
        logic [31:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = words[i]; step();
        end
        in_valid = 0;
        tests++; if (count !== 4'd3) begin fails++; $display("FAIL basic_count got=%0d exp=3", count); end
        tests++; if (out_data !== 32'h11) begin fails++; $display("FAIL basic_head got=%h exp=11", out_data); end
        tests++; if (in_cnt !== 16'd3) begin fails++; $display("FAIL basic_in_cnt got=%0d exp=3", in_cnt); end
        out_ready = 1;
        for (int i = 0; i < 3; i++) step();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (got_pops.size() <= i || got_pops[i] !== words[i]) begin
                fails++; $display("FAIL basic_pop%0d got=%h exp=%h", i, (got_pops.size() > i) ? got_pops[i] : 32'hx, words[i]);
            end
        end
        tests++; if (count !== 4'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain count=%0d valid=%b exp 0/0", count, out_valid); end
        tests++; if (out_cnt !== 16'd3) begin fails++; $display("FAIL basic_out_cnt got=%0d exp=3", out_cnt); end
        $display("[TB] test_basic done: pops=%0d", got_pops.size());
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_data = 32'hA0 + i; step();
            tests++;
            if (almost_full !== (i + 1 >= AF)) begin
                fails++; $display("FAIL full_af push%0d got=%b exp=%b", i + 1, almost_full, (i + 1 >= AF));
            end
        end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        in_valid = 1; in_data = 32'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (count !== 4'd8 || in_cnt !== 16'd8) begin
                fails++; $display("FAIL full_hold cyc%0d count=%0d in_cnt=%0d exp 8/8", i, count, in_cnt);
            end
        end
        out_ready = 1; step();
        out_ready = 0; step();
        in_valid = 0;
        tests++; if (count !== 4'd8 || in_cnt !== 16'd9) begin fails++; $display("FAIL full_refill count=%0d in_cnt=%0d exp 8/9", count, in_cnt); end
        out_ready = 1;
        for (int i = 0; i < 8; i++) step();
        out_ready = 0;
        tests++;
        if (got_pops.size() != 9 || got_pops[0] !== 32'hA0 || got_pops[8] !== 32'hFF) begin
            fails++; $display("FAIL full_order n=%0d first=%h last=%h exp 9/a0/ff", got_pops.size(),
                              (got_pops.size() > 0) ? got_pops[0] : 32'hx, (got_pops.size() > 8) ? got_pops[8] : 32'hx);
        end
        $display("[TB] test_full done: pops=%0d", got_pops.size());
    endtask

    task automatic test_back_to_back();
        int bad;
        apply_reset();
        push_words(4, 32'h100);
        in_valid = 1; out_ready = 1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            in_data = 32'h104 + i;
            step();
            tests++;
            if (count !== 4'd4) begin fails++; $display("FAIL b2b_count cyc%0d got=%0d exp=4", i, count); end
        end
        in_valid = 0; out_ready = 0;
        for (int i = 0; i < 20; i++) begin
            if (got_pops[i] !== 32'h100 + i) bad++;
        end
        tests++;
        if (bad != 0 || got_pops.size() != 20) begin fails++; $display("FAIL b2b_order bad=%0d n=%0d exp 0/20", bad, got_pops.size()); end
        $display("[TB] test_back_to_back done: pops=%0d", got_pops.size());
    endtask

    task automatic test_flush();
        apply_reset();
        push_words(5, 32'h200);
        flush = 1; in_valid = 1; out_ready = 1; in_data = 32'h2FF;
        step();
        flush = 0; in_valid = 0; out_ready = 0;
        tests++; if (count !== 4'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL flush_state count=%0d valid=%b exp 0/0", count, out_valid); end
        tests++; if (in_cnt !== 16'd5 || out_cnt !== 16'd0) begin fails++; $display("FAIL flush_cnts got=%0d/%0d exp 5/0", in_cnt, out_cnt); end
        $display("[TB] test_flush done");
    endtask

    task automatic test_async_reset();
        apply_reset();
        push_words(7, 32'h300);
        tests++; if (count !== 4'd7) begin fails++; $display("FAIL arst_pre count=%0d exp=7", count); end
        #3 rst_n = 0;
        #1;
        tests++;
        if (count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || almost_full !== 1'b0 || in_cnt !== 16'd0) begin
            fails++; $display("FAIL arst_clear count=%0d valid=%b ready=%b af=%b in_cnt=%0d exp 0/0/1/0/0",
                              count, out_valid, in_ready, almost_full, in_cnt);
        end
        q.delete(); m_in = 0; m_out = 0;
        #1 rst_n = 1;
        @(posedge clk); #1;
        in_valid = 1; in_data = 32'h5A; step();
        in_valid = 0;
        tests++; if (out_data !== 32'h5A || count !== 4'd1) begin fails++; $display("FAIL arst_push data=%h count=%0d exp 5a/1", out_data, count); end
        $display("[TB] test_async_reset done");
    endtask

    task automatic test_random();
        int bad;
        apply_reset();
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 40) == 0;
            in_data   = $urandom;
            step();
            tests++;
            if (count !== 4'(q.size()) || out_valid !== (q.size() != 0) || in_ready !== (q.size() != DEPTH)
                || almost_full !== (q.size() >= AF) || in_cnt !== 16'(m_in) || out_cnt !== 16'(m_out)
                || (q.size() != 0 && out_data !== q[0])) begin
                fails++;
                $display("FAIL rand_state cyc%0d count=%0d exp=%0d in_cnt=%0d exp=%0d out_cnt=%0d exp=%0d",
                         i, count, q.size(), in_cnt, 16'(m_in), out_cnt, 16'(m_out));
            end
        end
        in_valid = 0; out_ready = 0; flush = 0;
        for (int i = 0; i < exp_pops.size(); i++) if (got_pops[i] !== exp_pops[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL rand_order bad=%0d exp=0", bad); end
        $display("[TB] test_random done: pops=%0d", got_pops.size());
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        in_valid = 1; in_data = 0; step();
        out_ready = 1;
        for (int i = 1; i <= 65536; i++) begin
            in_data = i;
            step();
            if (i % 1024 == 0) begin exp_pops.delete(); got_pops.delete(); end
        end
        in_valid = 0; step();
        out_ready = 0;
        tests++; if (in_cnt !== 16'd1 || out_cnt !== 16'd1) begin fails++; $display("FAIL wrap_cnts got=%0d/%0d exp 1/1", in_cnt, out_cnt); end
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL wrap_count got=%0d exp=0", count); end
        $display("[TB] test_counter_wrap done");
    endtask

    initial begin
        rst_n = 0; in_valid = 0; out_ready = 0; flush = 0; in_data = '0;
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
